// File: rtl/pwm_dimmer.sv
// Push-button LED dimmer: two debounced buttons step a duty register,
// which drives a fixed-period PWM waveform through a period-aligned shadow.
//
// Ports:
//   CLK      - system clock, everything on the rising edge
//   RST      - asynchronous active-high reset
//   BTN_UP   - raw button, 1 = pressed, raises duty by STEP
//   BTN_DOWN - raw button, 1 = pressed, lowers duty by STEP
//   PWM      - registered dimmer waveform
//   DUTY     - current requested duty value
module pwm_dimmer #(
    parameter int PWM_BITS   = 8,
    parameter int PRESCALE   = 16,
    parameter int DEB_CYCLES = 50000,
    parameter int STEP       = 16,
    parameter int DUTY_INIT  = 128
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                BTN_UP,
    input  logic                BTN_DOWN,
    output logic                PWM,
    output logic [PWM_BITS-1:0] DUTY
);

    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [DW-1:0]       DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [PW-1:0]       PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [PWM_BITS-1:0] DMAX     = '1;
    // Counter runs 0..DMAX-1 so a full-scale shadow keeps PWM high.
    localparam logic [PWM_BITS-1:0] CNT_LAST = DMAX - 1'b1;
    localparam logic [PWM_BITS:0]   STEP_W   = (PWM_BITS + 1)'(STEP);
    localparam logic [PWM_BITS-1:0] INIT_W   = PWM_BITS'(DUTY_INIT);

    // Index 0 = up button, index 1 = down button.
    logic [1:0]         sync1_q, sync1_d;
    logic [1:0]         sync2_q, sync2_d;
    logic [1:0]         acc_q, acc_d;
    logic [1:0]         evt_q, evt_d;
    logic [1:0][DW-1:0] deb_q, deb_d;

    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic [PWM_BITS-1:0] shd_q, shd_d;
    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic [PW-1:0]       pre_q, pre_d;
    logic                pwm_q, pwm_d;

    logic                tick;
    logic                wrap;
    logic [PWM_BITS:0]   up_sum;
    logic [PWM_BITS-1:0] up_val;
    logic [PWM_BITS-1:0] dn_val;

    // Synchronizers, debounce counters and press-edge detection.
    always_comb begin
        sync1_d = {BTN_DOWN, BTN_UP};
        sync2_d = sync1_q;
        acc_d   = acc_q;
        deb_d   = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != acc_q[i]) begin
                if (deb_q[i] == DEB_LAST) begin
                    acc_d[i] = sync2_q[i];
                end else begin
                    deb_d[i] = deb_q[i] + 1'b1;
                end
            end
        end
        evt_d = acc_d & ~acc_q;
    end

    // Saturating duty update; math one bit wider to avoid wrap.
    always_comb begin
        up_sum = {1'b0, duty_q} + STEP_W;
        up_val = (up_sum > {1'b0, DMAX}) ? DMAX : up_sum[PWM_BITS-1:0];
        dn_val = ({1'b0, duty_q} < STEP_W) ? '0
                                           : duty_q - STEP_W[PWM_BITS-1:0];
        duty_d = duty_q;
        case (evt_q)
            2'b01:   duty_d = up_val;
            2'b10:   duty_d = dn_val;
            default: duty_d = duty_q;
        endcase
    end

    // Prescaler, period counter, shadow latch and PWM compare.
    always_comb begin
        tick  = (pre_q == PRE_LAST);
        wrap  = tick && (cnt_q == CNT_LAST);
        pre_d = tick ? '0 : pre_q + 1'b1;
        cnt_d = cnt_q;
        shd_d = shd_q;
        if (tick) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
        end
        // Shadow only moves at a period boundary.
        if (wrap) begin
            shd_d = duty_q;
        end
        pwm_d = (cnt_q < shd_q);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q <= '0;
            sync2_q <= '0;
            acc_q   <= '0;
            evt_q   <= '0;
            deb_q   <= '0;
            duty_q  <= INIT_W;
            shd_q   <= INIT_W;
            cnt_q   <= '0;
            pre_q   <= '0;
            pwm_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            acc_q   <= acc_d;
            evt_q   <= evt_d;
            deb_q   <= deb_d;
            duty_q  <= duty_d;
            shd_q   <= shd_d;
            cnt_q   <= cnt_d;
            pre_q   <= pre_d;
            pwm_q   <= pwm_d;
        end
    end

    assign PWM  = pwm_q;
    assign DUTY = duty_q;

endmodule

// File: tb/tb_pwm_dimmer.sv
// Scoreboard bench for pwm_dimmer: button presses push expected duty
// changes, monitors compare duty steps and per-period PWM high counts.
module tb_pwm_dimmer;

    localparam int DEB = 4;
    localparam int LAT = DEB + 3;
    localparam int PER = 255;
    localparam int HOLD = DEB + 6;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       up = 1'b0;
    logic       dn = 1'b0;
    logic       z = 1'b0;
    logic       pwm1, pwm2;
    logic [7:0] duty1, duty2;

    pwm_dimmer #(
        .PWM_BITS(8), .PRESCALE(1), .DEB_CYCLES(DEB),
        .STEP(16), .DUTY_INIT(128)
    ) u1 (
        .CLK(clk), .RST(rst), .BTN_UP(up), .BTN_DOWN(dn),
        .PWM(pwm1), .DUTY(duty1)
    );

    pwm_dimmer #(
        .PWM_BITS(8), .PRESCALE(4), .DEB_CYCLES(DEB),
        .STEP(16), .DUTY_INIT(1)
    ) u2 (
        .CLK(clk), .RST(rst), .BTN_UP(z), .BTN_DOWN(z),
        .PWM(pwm2), .DUTY(duty2)
    );

    always #5 clk = ~clk;

    // Rising edges since the last reset release.
    int ncyc;
    always @(posedge clk or posedge rst) begin
        if (rst) ncyc <= 0;
        else     ncyc <= ncyc + 1;
    end

    int chk = 0;
    int pass = 0;

    task automatic check(input string nm, input int act, input int exp);
        chk++;
        if (act == exp) pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)",
                      nm, act, exp, $time);
    endtask

    typedef struct {
        int val;
        int cyc;
    } exp_t;

    exp_t dq[$];
    int   pq[$];
    int   model_duty = 128;

    // Duty monitor: every observed change must match the next expectation.
    initial begin
        int   dprev;
        exp_t e;
        dprev = 128;
        forever begin
            @(negedge clk);
            if (rst) begin
                dprev = int'(duty1);
                continue;
            end
            if (int'(duty1) != dprev) begin
                if (dq.size() == 0) begin
                    check("duty_unexpected", int'(duty1), dprev);
                end else begin
                    e = dq.pop_front();
                    check("duty_val", int'(duty1), e.val);
                    check("duty_cyc", ncyc, e.cyc);
                end
                dprev = int'(duty1);
            end
        end
    end

    // PWM monitor: each period must be exactly S high cycles, front-loaded,
    // where S is the duty held just before the period boundary.
    initial begin
        int hi, bad, sawlow, started, dlast, n, pos, s;
        hi = 0; bad = 0; sawlow = 0; started = 0; dlast = 128;
        forever begin
            @(negedge clk);
            if (rst) begin
                pq.delete();
                pq.push_back(128);
                started = 0;
                dlast = int'(duty1);
                continue;
            end
            n = ncyc;
            if (n == 0) begin
                dlast = int'(duty1);
                continue;
            end
            pos = (n - 1) % PER;
            if (pos == 0) begin
                if (started != 0) begin
                    s = (pq.size() != 0) ? pq.pop_front() : -1;
                    check("period_high", hi, s);
                    check("period_shape", bad, 0);
                end
                started = 1;
                hi = 0;
                sawlow = 0;
                bad = 0;
            end
            if (pwm1) begin
                hi++;
                if (sawlow != 0) bad = 1;
            end else begin
                sawlow = 1;
            end
            if (n % PER == 0) pq.push_back(dlast);
            dlast = int'(duty1);
        end
    end

    task automatic press(input logic u, input logic d, input bit bounce);
        int   nv;
        exp_t e;
        nv = model_duty;
        if (u && !d) nv = (model_duty + 16 > 255) ? 255 : model_duty + 16;
        if (d && !u) nv = (model_duty < 16) ? 0 : model_duty - 16;
        if (bounce) begin
            up = u; dn = d;
            @(negedge clk);
            up = 1'b0; dn = 1'b0;
            @(negedge clk);
        end
        up = u; dn = d;
        if (nv != model_duty) begin
            e.val = nv;
            e.cyc = ncyc + LAT;
            dq.push_back(e);
        end
        model_duty = nv;
        repeat (HOLD) @(negedge clk);
        up = 1'b0; dn = 1'b0;
        repeat (HOLD) @(negedge clk);
    endtask

    task automatic glitch(input bit on_up);
        int len;
        len = $urandom_range(1, DEB - 1);
        if (on_up) up = 1'b1;
        else       dn = 1'b1;
        repeat (len) @(negedge clk);
        up = 1'b0; dn = 1'b0;
        repeat (HOLD) @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        exp_t e;
        int   op;
        rst = 1'b1;
        #1;
        check("rst_duty", int'(duty1), 128);
        check("rst_pwm", int'(pwm1), 0);
        check("rst_duty2", int'(duty2), 1);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int w = 0; w < 2; w++) begin
            int tot, early;
            tot = 0; early = 0;
            for (int k = 1; k <= 1020; k++) begin
                @(negedge clk);
                if (pwm2) begin
                    tot++;
                    if (k <= 4) early++;
                end
            end
            check("pre_total", tot, 4);
            check("pre_early", early, 4);
        end

        for (int i = 0; i < 10; i++) press(1'b1, 1'b0, i == 0);
        repeat (600) @(negedge clk);

        // Reset between edges while saturated, button held through release.
        up = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_duty", int'(duty1), 128);
        check("mid_rst_pwm", int'(pwm1), 0);
        dq.delete();
        model_duty = 128;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        e.val = 144;
        e.cyc = LAT;
        dq.push_back(e);
        model_duty = 144;
        repeat (HOLD) @(negedge clk);
        up = 1'b0;
        repeat (HOLD) @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 5);
            case (op)
                0:       press(1'b1, 1'b0, 1'b0);
                1:       press(1'b1, 1'b0, 1'b1);
                2:       press(1'b0, 1'b1, 1'b0);
                3:       press(1'b1, 1'b1, 1'b0);
                4:       glitch(1'b1);
                default: glitch(1'b0);
            endcase
        end

        for (int i = 0; i < 20; i++) press(1'b0, 1'b1, i == 0);
        repeat (600) @(negedge clk);

        check("dq_drained", dq.size(), 0);
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

endmodule
